tt_um_delta_integrator: RTL and testbench

Receive-side counterpart of the team's 8-bit subtractor tile. The subtractor emits mod-256 differences between successive samples; this tile reconstructs the samples by accumulating those differences. Each delta is delivered under a strobe/ack handshake driven by an external host on the Tiny Tapeout pins. Supports seed loading, wrap or saturating arithmetic, and a sticky overflow flag.

---
 rtl/tt_um_delta_integrator.sv | 105 ++++++++++
 tb/tb_tt_um_delta_integrator.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_delta_integrator.sv
// Delta integrator: rebuilds samples from the subtractor tile's mod-256 differences.
// One delta (or seed) per strobe/ack handshake, with wrap/saturate modes and a sticky overflow.
module tt_um_delta_integrator (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       s1, s2, s3, rise;
  logic [7:0] d_r, acc, acc_d;
  logic       load_r, sat_r;
  logic       ovf, ovf_d, ack, ready, ready_d;
  logic [9:0] t;
  logic       unused_ok;

  // All three start high so a strobe held across reset release never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= uio_in[0];
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  // Range is -128..382, so bit 9 flags a negative sum and bit 8 a sum above 255.
  assign t = {2'b00, acc} + {{2{d_r[7]}}, d_r};

  always_comb begin
    state_d = state_q;
    acc_d   = acc;
    ovf_d   = ovf;
    case (state_q)
      IDLE: begin
        if (rise) state_d = APPLY;
      end
      APPLY: begin
        state_d = HOLD;
        if (load_r) begin
          acc_d = d_r;
          ovf_d = 1'b0;
        end else begin
          if (t[9] | t[8]) ovf_d = 1'b1;
          if (sat_r && t[9])      acc_d = 8'h00;
          else if (sat_r && t[8]) acc_d = 8'hFF;
          else                    acc_d = t[7:0];
        end
      end
      HOLD: begin
        if (!s2) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready_d = (state_d == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc     <= 8'h00;
      ovf     <= 1'b0;
      ack     <= 1'b0;
      ready   <= 1'b1;
      d_r     <= 8'h00;
      load_r  <= 1'b0;
      sat_r   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc     <= acc_d;
      ovf     <= ovf_d;
      ready   <= ready_d;
      if (state_q == APPLY) ack <= ~ack;
      // Data pins are safe to sample unsynchronized: the host holds them stable well before strobe.
      if (state_q == IDLE && rise) begin
        d_r    <= ui_in;
        load_r <= uio_in[1];
        sat_r  <= uio_in[2];
      end
    end
  end

  assign uo_out    = acc;
  assign uio_out   = {(acc == 8'h00), ready, ovf, ack, 4'b0000};
  assign uio_oe    = 8'hF0;
  assign unused_ok = &{1'b0, ena, uio_in[7:3]};

endmodule

// File: tb/tb_tt_um_delta_integrator.sv
// Bench for tt_um_delta_integrator: directed handshake steps plus random deltas,
// checked against an integer model of the accumulator, overflow flag and ack toggle.
module tb_tt_um_delta_integrator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;

  int checks = 0;
  int errors = 0;

  int m_acc = 0;
  bit m_ovf = 1'b0;
  bit m_ack = 1'b0;

  tt_um_delta_integrator dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] exp_status(input bit rdy);
    return {(m_acc == 0), rdy, m_ovf, m_ack, 4'b0000};
  endfunction

  // Reference behaviour: plain integer arithmetic on the reconstructed sample.
  task automatic model_apply(input bit ld, input bit st, input logic [7:0] d);
    int sd;
    int sum;
    sd = $signed(d);
    if (ld) begin
      m_acc = int'(d);
      m_ovf = 1'b0;
    end else begin
      sum = m_acc + sd;
      if (sum < 0 || sum > 255) m_ovf = 1'b1;
      if (st) m_acc = (sum < 0) ? 0 : ((sum > 255) ? 255 : sum);
      else    m_acc = ((sum % 256) + 256) % 256;
    end
    m_ack = ~m_ack;
  endtask

  task automatic model_reset();
    m_acc = 0;
    m_ovf = 1'b0;
    m_ack = 1'b0;
  endtask

  task automatic do_reset(input bit strobe_level);
    @(negedge clk);
    uio_in[0] = strobe_level;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_uo_out", uo_out, 8'h00);
    checkOutput("rst_uio_out", uio_out, 8'hC0);
    checkOutput("rst_uio_oe", uio_oe, 8'hF0);
  endtask

  // One full event: set operands, raise strobe, verify 4-edge latency, hold, release, verify ready.
  task automatic applyStimulus(input bit ld, input bit st, input logic [7:0] d, input int hold);
    @(negedge clk);
    ui_in  = d;
    uio_in = {5'b00000, st, ld, 1'b0};
    repeat (2) @(negedge clk);
    uio_in[0] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("acc_before_e4", uo_out, 8'(m_acc));
    checkOutput("status_apply", uio_out, exp_status(1'b0));
    @(posedge clk);
    model_apply(ld, st, d);
    @(negedge clk);
    checkOutput("acc_after_e4", uo_out, 8'(m_acc));
    checkOutput("status_after_e4", uio_out, exp_status(1'b0));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput("status_hold", uio_out, exp_status(1'b0));
    end
    uio_in[0] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("ready_after_l2", uio_out, exp_status(1'b0));
    @(posedge clk);
    @(negedge clk);
    checkOutput("ready_after_l3", uio_out, exp_status(1'b1));
  endtask

  initial begin
    bit         ld, st;
    logic [7:0] d;
    int         hold;
    logic [7:0] samples [4];

    $display("[TB] start");

    // Reset with strobe low, then with strobe held high through release.
    do_reset(1'b0);
    do_reset(1'b1);
    repeat (10) @(negedge clk);
    checkOutput("strobe_high_rst_no_ack", uio_out, 8'hC0);
    uio_in[0] = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("strobe_high_rst_idle", uio_out, 8'hC0);

    // Load then wrap.
    applyStimulus(1'b1, 1'b0, 8'hF0, 0);
    checkOutput("load_f0_acc", uo_out, 8'hF0);
    checkOutput("load_f0_status", uio_out, 8'h50);
    applyStimulus(1'b0, 1'b0, 8'h20, 1);
    checkOutput("wrap_acc", uo_out, 8'h10);
    checkOutput("wrap_status", uio_out, 8'h60);

    // Saturation at both ends, sticky ovf, clear on load.
    applyStimulus(1'b1, 1'b0, 8'h05, 0);
    applyStimulus(1'b0, 1'b1, 8'h80, 0);
    checkOutput("sat_low_acc", uo_out, 8'h00);
    checkOutput("sat_low_zero_ovf", uio_out & 8'hA0, 8'hA0);
    applyStimulus(1'b0, 1'b1, 8'h7F, 0);
    checkOutput("sat_add_acc", uo_out, 8'h7F);
    checkOutput("ovf_sticky", uio_out & 8'h20, 8'h20);
    applyStimulus(1'b1, 1'b1, 8'h00, 0);
    checkOutput("load_clears_ovf", uio_out & 8'h20, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'hFA, 0);
    applyStimulus(1'b0, 1'b1, 8'h10, 0);
    checkOutput("sat_high_acc", uo_out, 8'hFF);

    // Round trip with subtractor-style deltas.
    samples[0] = 8'd10;
    samples[1] = 8'd250;
    samples[2] = 8'd3;
    samples[3] = 8'd128;
    applyStimulus(1'b1, 1'b0, samples[0], 0);
    checkOutput("roundtrip_0", uo_out, samples[0]);
    for (int n = 1; n < 4; n++) begin
      applyStimulus(1'b0, 1'b0, 8'(samples[n] - samples[n-1]), 0);
      checkOutput("roundtrip_n", uo_out, samples[n]);
    end

    // Reset asserted while in APPLY; strobe stays high across release.
    applyStimulus(1'b1, 1'b0, 8'h55, 0);
    @(negedge clk);
    ui_in  = 8'h11;
    uio_in = 8'h00;
    repeat (2) @(negedge clk);
    uio_in[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    checkOutput("midrst_acc", uo_out, 8'h00);
    checkOutput("midrst_status", uio_out, 8'hC0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("midrst_no_event", uio_out, 8'hC0);
    checkOutput("midrst_acc_hold", uo_out, 8'h00);
    uio_in[0] = 1'b0;
    repeat (4) @(negedge clk);
    applyStimulus(1'b0, 1'b0, 8'h03, 0);
    checkOutput("after_midrst_event", uo_out, 8'h03);

    // Long strobe: one ack toggle, ready low throughout.
    applyStimulus(1'b0, 1'b0, 8'h01, 20);

    // Random deltas, loads and modes.
    for (int i = 0; i < 24; i++) begin
      ld   = ($urandom_range(0, 7) == 0);
      st   = 1'($urandom_range(0, 1));
      d    = 8'($urandom);
      hold = $urandom_range(0, 3);
      applyStimulus(ld, st, d, hold);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
